// File: rtl/rd_guard_pkg.sv
// rd_guard_pkg: shared types and helpers for the read-latency guard.
//   slot_state_e    : per-slot FSM state (FREE, WAIT_FIRST, STREAMING)
//   RD_GUARD_SLOT_T : macro that declares the parameterised slot_t record
//                     inside a module, sized by ID/txn/budget widths
//   slot_idx_w()    : index width for a given slot count (min 1)
`ifndef RD_GUARD_PKG_SV
`define RD_GUARD_PKG_SV

// Expand inside a module that imports rd_guard_pkg; declares type slot_t.
`define RD_GUARD_SLOT_T(IDW, TW, BW) \
    typedef struct packed { \
        slot_state_e        state; \
        logic               frozen; \
        logic [(IDW)-1:0]   id; \
        logic [(TW)-1:0]    num_txn; \
        logic [(BW)-1:0]    cnt; \
    } slot_t;

package rd_guard_pkg;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_FIRST = 2'd1,
        STREAMING  = 2'd2
    } slot_state_e;

    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/rd_guard_slot.sv
// rd_guard_slot: one tracked read ID - slot FSM, outstanding-txn counter and
// budget down-counter. The top decides which slot sees alloc/ar_hit/r_hit.
// Optional feature macro: RD_GUARD_LAT_STATS_EN (adds lat_valid/lat outputs).
// Ports:
//   clk, rst        clock, async active-high reset
//   tick            prescaled count enable
//   clear           free the slot (sticky-clear from the top)
//   alloc           claim this FREE slot for ar_id
//   ar_hit, r_hit   AR / R handshake for this slot's ID
//   r_last          R beat is the last of its burst
//   ar_id           ID to latch on alloc
//   first_budget    reload value for AR -> first R
//   beat_budget     reload value between R beats
//   busy, id, sat   slot occupied, its ID, txn counter saturated
//   expire          budget ran out this cycle
//   lat_valid, lat  first-beat latency sample (stats build only)
module rd_guard_slot
    import rd_guard_pkg::*;
#(
    parameter int IdWidth     = 4,
    parameter int TxnCntWidth = 3,
    parameter int BudgetWidth = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   clear,
    input  logic                   alloc,
    input  logic                   ar_hit,
    input  logic                   r_hit,
    input  logic                   r_last,
    input  logic [IdWidth-1:0]     ar_id,
    input  logic [BudgetWidth-1:0] first_budget,
    input  logic [BudgetWidth-1:0] beat_budget,
    output logic                   busy,
    output logic [IdWidth-1:0]     id,
    output logic                   sat,
    output logic                   expire
`ifdef RD_GUARD_LAT_STATS_EN
    ,
    output logic                   lat_valid,
    output logic [BudgetWidth-1:0] lat
`endif
);

    `RD_GUARD_SLOT_T(IdWidth, TxnCntWidth, BudgetWidth)

    slot_t                  cur, nxt;
    logic [TxnCntWidth-1:0] txn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= '0;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        // AR and R-last in the same cycle cancel, so a slot about to drain
        // is kept when a new AR for its ID arrives.
        txn = cur.num_txn + TxnCntWidth'(ar_hit) - TxnCntWidth'(r_hit & r_last);
        if (clear) begin
            nxt = '0;
        end else if (alloc) begin
            nxt.state   = WAIT_FIRST;
            nxt.frozen  = 1'b0;
            nxt.id      = ar_id;
            nxt.num_txn = TxnCntWidth'(1);
            nxt.cnt     = first_budget;
        end else if (cur.state != FREE && !cur.frozen) begin
            nxt.num_txn = txn;
            if (r_hit) begin
                if (r_last && txn == '0) begin
                    nxt.state = FREE;
                    nxt.cnt   = '0;
                end else if (r_last) begin
                    nxt.state = WAIT_FIRST;
                    nxt.cnt   = first_budget;
                end else begin
                    nxt.state = STREAMING;
                    nxt.cnt   = beat_budget;
                end
            end else if (tick) begin
                // A tick that finds the counter at zero is the timeout; the
                // slot then holds its contents for post-mortem until cleared.
                if (cur.cnt == '0) nxt.frozen = 1'b1;
                else               nxt.cnt    = cur.cnt - BudgetWidth'(1);
            end
        end
    end

    always_comb begin
        busy   = (cur.state != FREE);
        id     = cur.id;
        sat    = &cur.num_txn;
        expire = busy && !cur.frozen && tick && !r_hit && (cur.cnt == '0);
    end

`ifdef RD_GUARD_LAT_STATS_EN
    logic [BudgetWidth-1:0] lat_base;

    // Remember the first-beat budget actually loaded so latency is exact
    // even if first_budget changes while the slot waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lat_base <= '0;
        else if (alloc || (r_hit && r_last && busy && !cur.frozen))
            lat_base <= first_budget;
    end

    assign lat_valid = r_hit && !cur.frozen && (cur.state == WAIT_FIRST);
    assign lat       = lat_base - cur.cnt;
`endif

endmodule

// File: rtl/rd_latency_guard.sv
// rd_latency_guard: passive per-ID AXI read watchdog. Tracks up to NumSlots
// distinct read IDs, times AR -> first R and R beat -> beat against two
// budgets, and raises a sticky reset request plus a one-cycle IRQ on expiry.
// Optional feature macro: RD_GUARD_LAT_STATS_EN (adds max_lat_o).
// Ports:
//   clk_i, rst_i               clock, async active-high reset
//   en_i                       accept new ARs (existing slots always drain)
//   ar_valid_i/ready_i/id_i    AR handshake observation
//   r_valid_i/ready_i/id_i     R handshake observation
//   r_last_i                   R last beat
//   first_budget_i             ticks from AR accept to first R beat
//   beat_budget_i              ticks between R beats
//   reset_clear_i              clear sticky outputs and free all slots
//   reset_req_o, irq_o         sticky reset request, rising-edge pulse
//   timeout_slot_o             lowest slot that expired first
//   full_o                     no free slot
//   err_unexp_o, err_ovf_o     sticky: untracked R, dropped AR
//   max_lat_o                  worst first-beat latency (stats build only)
module rd_latency_guard
    import rd_guard_pkg::*;
#(
    parameter  int IdWidth      = 4,
    parameter  int NumSlots     = 8,
    parameter  int TxnCntWidth  = 3,
    parameter  int BudgetWidth  = 10,
    parameter  int PrescalerDiv = 1,
    localparam int SlotIdxW     = slot_idx_w(NumSlots)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   ar_valid_i,
    input  logic                   ar_ready_i,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic                   r_valid_i,
    input  logic                   r_ready_i,
    input  logic [IdWidth-1:0]     r_id_i,
    input  logic                   r_last_i,
    input  logic [BudgetWidth-1:0] first_budget_i,
    input  logic [BudgetWidth-1:0] beat_budget_i,
    input  logic                   reset_clear_i,
    output logic                   reset_req_o,
    output logic                   irq_o,
    output logic [SlotIdxW-1:0]    timeout_slot_o,
    output logic                   full_o,
    output logic                   err_unexp_o,
    output logic                   err_ovf_o
`ifdef RD_GUARD_LAT_STATS_EN
    ,
    output logic [BudgetWidth-1:0] max_lat_o
`endif
);

    localparam int PreW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

    logic                                busy_all;
    logic [NumSlots-1:0]                 busy, sat, expire;
    logic [NumSlots-1:0]                 ar_match, r_match, ar_hit, r_hit, alloc;
    logic [NumSlots-1:0][IdWidth-1:0]    slot_id;
    logic                                ar_fire, r_fire, ar_any, ar_sat, have_free;
    logic                                ovf_evt, unexp_evt, any_exp;
    logic [SlotIdxW-1:0]                 free_idx, exp_idx;
    logic                                tick;

    // ---------------- prescaler ----------------
    generate
        if (PrescalerDiv <= 1) begin : g_no_pre
            assign tick = 1'b1;
        end else begin : g_pre
            logic [PreW-1:0] pre_cnt;
            logic            tick_q;
            // Registered tick: one clean pulse every PrescalerDiv cycles.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pre_cnt <= '0;
                    tick_q  <= 1'b0;
                end else if (pre_cnt == PreW'(PrescalerDiv - 1)) begin
                    pre_cnt <= '0;
                    tick_q  <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + PreW'(1);
                    tick_q  <= 1'b0;
                end
            end
            assign tick = tick_q;
        end
    endgenerate

    // ---------------- match / allocate ----------------
    assign ar_fire = ar_valid_i & ar_ready_i & en_i;
    assign r_fire  = r_valid_i & r_ready_i;

    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            ar_match[i] = busy[i] && (slot_id[i] == ar_id_i);
            r_match[i]  = busy[i] && (slot_id[i] == r_id_i);
        end
    end

    // Lowest-index free slot and lowest-index expiring slot.
    always_comb begin
        free_idx  = '0;
        have_free = 1'b0;
        exp_idx   = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx  = SlotIdxW'(i);
                have_free = 1'b1;
            end
            if (expire[i]) exp_idx = SlotIdxW'(i);
        end
    end

    assign ar_any    = |ar_match;
    assign ar_sat    = |(ar_match & sat);
    assign any_exp   = |expire;
    assign busy_all  = &busy;
    assign ovf_evt   = ar_fire && (ar_any ? ar_sat : !have_free);
    assign unexp_evt = r_fire && !(|r_match);

    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            ar_hit[i] = ar_fire && !ar_sat && ar_match[i];
            r_hit[i]  = r_fire && r_match[i];
            alloc[i]  = ar_fire && !ar_any && have_free && (free_idx == SlotIdxW'(i));
        end
    end

    // ---------------- slots ----------------
`ifdef RD_GUARD_LAT_STATS_EN
    logic [NumSlots-1:0]                  lat_valid;
    logic [NumSlots-1:0][BudgetWidth-1:0] lat;
`endif

    generate
        for (genvar g = 0; g < NumSlots; g++) begin : g_slot
            rd_guard_slot #(
                .IdWidth     (IdWidth),
                .TxnCntWidth (TxnCntWidth),
                .BudgetWidth (BudgetWidth)
            ) u_slot (
                .clk          (clk_i),
                .rst          (rst_i),
                .tick         (tick),
                .clear        (reset_clear_i),
                .alloc        (alloc[g]),
                .ar_hit       (ar_hit[g]),
                .r_hit        (r_hit[g]),
                .r_last       (r_last_i),
                .ar_id        (ar_id_i),
                .first_budget (first_budget_i),
                .beat_budget  (beat_budget_i),
                .busy         (busy[g]),
                .id           (slot_id[g]),
                .sat          (sat[g]),
                .expire       (expire[g])
`ifdef RD_GUARD_LAT_STATS_EN
                ,
                .lat_valid    (lat_valid[g]),
                .lat          (lat[g])
`endif
            );
        end
    endgenerate

    // ---------------- sticky flags ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reset_req_o    <= 1'b0;
            irq_o          <= 1'b0;
            timeout_slot_o <= '0;
            err_unexp_o    <= 1'b0;
            err_ovf_o      <= 1'b0;
        end else if (reset_clear_i) begin
            reset_req_o    <= 1'b0;
            irq_o          <= 1'b0;
            timeout_slot_o <= '0;
            err_unexp_o    <= 1'b0;
            err_ovf_o      <= 1'b0;
        end else begin
            // Only the first expiry is reported; later ones are absorbed.
            irq_o       <= any_exp && !reset_req_o;
            reset_req_o <= reset_req_o | any_exp;
            if (any_exp && !reset_req_o) timeout_slot_o <= exp_idx;
            err_unexp_o <= err_unexp_o | unexp_evt;
            err_ovf_o   <= err_ovf_o | ovf_evt;
        end
    end

    assign full_o = busy_all;

`ifdef RD_GUARD_LAT_STATS_EN
    logic [BudgetWidth-1:0] max_lat_q, lat_cand;

    always_comb begin
        lat_cand = max_lat_q;
        for (int i = 0; i < NumSlots; i++)
            if (lat_valid[i] && lat[i] > lat_cand) lat_cand = lat[i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              max_lat_q <= '0;
        else if (reset_clear_i) max_lat_q <= '0;
        else                    max_lat_q <= lat_cand;
    end

    assign max_lat_o = max_lat_q;
`endif

endmodule

// File: tb/tb_rd_latency_guard.sv
// tb_rd_latency_guard: directed bench for rd_latency_guard. A deadline-based
// reference model (tick timestamps per tracked ID) predicts every output each
// cycle; directed literal checks pin the model at key points. A second
// instance with PrescalerDiv=4 checks the prescaled expiry window.
module tb_rd_latency_guard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       ar_valid = 1'b0, ar_ready = 1'b0;
    logic [3:0] ar_id = '0;
    logic       r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
    logic [3:0] r_id = '0;
    logic [9:0] fb = 10'd5, bb = 10'd3;
    logic       reset_clear = 1'b0;
    logic       reset_req, irq, full, err_unexp, err_ovf;
    logic [2:0] timeout_slot;

    logic       ar4_valid = 1'b0;
    logic [3:0] ar4_id = '0;
    logic       reset_req4, irq4, full4, err_unexp4, err_ovf4;
    logic [2:0] timeout_slot4;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    rd_latency_guard #(.PrescalerDiv(1)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_id_i(ar_id),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_id_i(r_id), .r_last_i(r_last),
        .first_budget_i(fb), .beat_budget_i(bb), .reset_clear_i(reset_clear),
        .reset_req_o(reset_req), .irq_o(irq), .timeout_slot_o(timeout_slot),
        .full_o(full), .err_unexp_o(err_unexp), .err_ovf_o(err_ovf)
`ifdef RD_GUARD_LAT_STATS_EN
        , .max_lat_o()
`endif
    );

    rd_latency_guard #(.PrescalerDiv(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(1'b1),
        .ar_valid_i(ar4_valid), .ar_ready_i(ar4_valid), .ar_id_i(ar4_id),
        .r_valid_i(1'b0), .r_ready_i(1'b0), .r_id_i(4'd0), .r_last_i(1'b0),
        .first_budget_i(10'd2), .beat_budget_i(10'd2), .reset_clear_i(1'b0),
        .reset_req_o(reset_req4), .irq_o(irq4), .timeout_slot_o(timeout_slot4),
        .full_o(full4), .err_unexp_o(err_unexp4), .err_ovf_o(err_ovf4)
`ifdef RD_GUARD_LAT_STATS_EN
        , .max_lat_o()
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each tracked ID records the tick count at its last reload and the
    // budget loaded; it is overdue once that many ticks have elapsed.
    int m_busy[8], m_frz[8], m_id[8], m_ntx[8], m_rel[8], m_bud[8];
    int m_t = 0, m_req = 0, m_irq = 0, m_ts = 0, m_unexp = 0, m_ovf = 0;

    task automatic model_step();
        int e[8];
        int pf[8];
        int ai, ri, fi, le, inc, n, arf, rf, rh;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_busy[i] = 0; m_frz[i] = 0; end
            m_req = 0; m_irq = 0; m_ts = 0; m_unexp = 0; m_ovf = 0;
            return;
        end
        arf = ar_valid && ar_ready && en;
        rf  = r_valid && r_ready;
        ai = -1; ri = -1; fi = -1; le = -1;
        for (int i = 7; i >= 0; i--) begin
            pf[i] = m_frz[i];
            if (m_busy[i] != 0 && m_id[i] == int'(ar_id)) ai = i;
            if (m_busy[i] != 0 && m_id[i] == int'(r_id)) ri = i;
            if (m_busy[i] == 0) fi = i;
        end
        rh = (rf != 0 && ri >= 0) ? (pf[ri] == 0) : 0;
        for (int i = 7; i >= 0; i--) begin
            e[i] = (m_busy[i] != 0 && m_frz[i] == 0 && (m_t - m_rel[i] >= m_bud[i])
                    && !(rf != 0 && ri == i)) ? 1 : 0;
            if (e[i] != 0) le = i;
        end
        m_t++;
        if (reset_clear) begin
            for (int i = 0; i < 8; i++) begin m_busy[i] = 0; m_frz[i] = 0; end
            m_req = 0; m_irq = 0; m_ts = 0; m_unexp = 0; m_ovf = 0;
            return;
        end
        m_irq = (m_req == 0 && le >= 0) ? 1 : 0;
        if (m_irq != 0) m_ts = le;
        if (le >= 0) m_req = 1;
        inc = 0;
        if (arf != 0) begin
            if (ai >= 0) begin
                if (m_ntx[ai] == 7) m_ovf = 1;
                else if (pf[ai] == 0) inc = 1;
            end else if (fi >= 0) begin
                m_busy[fi] = 1; m_frz[fi] = 0; m_id[fi] = int'(ar_id);
                m_ntx[fi] = 1; m_rel[fi] = m_t; m_bud[fi] = int'(fb);
            end else m_ovf = 1;
        end
        if (rf != 0 && ri < 0) m_unexp = 1;
        if (inc != 0 && !(rh != 0 && ai == ri)) m_ntx[ai]++;
        if (rh != 0) begin
            n = m_ntx[ri] + ((inc != 0 && ai == ri) ? 1 : 0) - (r_last ? 1 : 0);
            m_ntx[ri] = n;
            if (r_last && n == 0) m_busy[ri] = 0;
            else begin
                m_rel[ri] = m_t;
                m_bud[ri] = r_last ? int'(fb) : int'(bb);
            end
        end
        for (int i = 0; i < 8; i++) if (e[i] != 0) m_frz[i] = 1;
    endtask

    function automatic int m_full();
        int f = 1;
        for (int i = 0; i < 8; i++) if (m_busy[i] == 0) f = 0;
        return f;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en && !rst) begin
            chk("model.reset_req", reset_req, m_req);
            chk("model.irq", irq, m_irq);
            chk("model.timeout_slot", timeout_slot, m_ts);
            chk("model.full", full, m_full());
            chk("model.err_unexp", err_unexp, m_unexp);
            chk("model.err_ovf", err_ovf, m_ovf);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic ar_pulse(input int id);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_id = 4'(id);
        cyc();
        ar_valid = 1'b0; ar_ready = 1'b0;
    endtask

    task automatic r_beat(input int id, input bit last);
        r_valid = 1'b1; r_ready = 1'b1; r_id = 4'(id); r_last = last;
        cyc();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    endtask

    task automatic do_clear();
        reset_clear = 1'b1;
        cyc();
        reset_clear = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        samp();
        chk("rst.reset_req", reset_req, 0);
        chk("rst.irq", irq, 0);
        chk("rst.full", full, 0);
        chk("rst.errs", {err_unexp, err_ovf}, 0);
        @(posedge clk); #1 rst = 1'b0;
        cmp_en = 1'b1;

        // 1: normal read, first beat after 4 cycles, 4 back-to-back beats
        fb = 10'd5; bb = 10'd3;
        ar_pulse(2);
        repeat (3) cyc();
        for (int k = 0; k < 4; k++) r_beat(2, k == 3);
        repeat (3) cyc();
        samp();
        chk("t1.reset_req", reset_req, 0);

        // 2: first-beat timeout; slot 0 must have been freed by test 1
        ar_pulse(1);
        repeat (5) cyc();
        samp();
        chk("t2.before", reset_req, 0);
        cyc(); samp();
        chk("t2.reset_req", reset_req, 1);
        chk("t2.irq", irq, 1);
        chk("t2.slot", timeout_slot, 0);
        cyc(); samp();
        chk("t2.irq_pulse", irq, 0);
        chk("t2.sticky", reset_req, 1);
        do_clear(); samp();
        chk("t2.cleared", {reset_req, irq, full, err_unexp, err_ovf}, 0);

        // 3: fill all slots, overflow, then drain one
        fb = 10'd1000; bb = 10'd1000;
        for (int k = 0; k < 8; k++) ar_pulse(k);
        samp();
        chk("t3.full", full, 1);
        chk("t3.no_ovf", err_ovf, 0);
        ar_pulse(8);
        samp();
        chk("t3.ovf", err_ovf, 1);
        r_beat(8, 1'b1);
        samp();
        chk("t3.untracked", err_unexp, 1);
        r_beat(0, 1'b1);
        samp();
        chk("t3.not_full", full, 0);
        do_clear();

        // 4: R for an ID never issued
        r_beat(7, 1'b1);
        samp();
        chk("t4.unexp", err_unexp, 1);
        chk("t4.no_req", reset_req, 0);
        do_clear();

        // txn counter saturation: 7 outstanding fit, 8th is dropped
        for (int k = 0; k < 7; k++) ar_pulse(6);
        samp();
        chk("sat.ok", err_ovf, 0);
        ar_pulse(6);
        samp();
        chk("sat.ovf", err_ovf, 1);
        do_clear();

        // 5: AR and R-last on the same ID/cycle keeps the slot, reloads first budget
        fb = 10'd5; bb = 10'd3;
        ar_pulse(3);
        repeat (2) cyc();
        ar_valid = 1'b1; ar_ready = 1'b1; ar_id = 4'd3;
        r_valid = 1'b1; r_ready = 1'b1; r_id = 4'd3; r_last = 1'b1;
        cyc();
        ar_valid = 1'b0; ar_ready = 1'b0;
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
        repeat (5) cyc();
        samp();
        chk("t5.reloaded", reset_req, 0);
        cyc(); samp();
        chk("t5.expired", reset_req, 1);
        chk("t5.slot", timeout_slot, 0);
        do_clear();

        // budget 0 expires on the next cycle
        fb = 10'd0;
        ar_pulse(5);
        samp();
        chk("b0.not_yet", reset_req, 0);
        cyc(); samp();
        chk("b0.expired", reset_req, 1);
        do_clear();

        // clear wins over a simultaneous expiry
        fb = 10'd2;
        ar_pulse(4);
        repeat (2) cyc();
        do_clear(); samp();
        chk("clrwin.req", reset_req, 0);
        chk("clrwin.irq", irq, 0);

        // en_i low: AR ignored, nothing times out
        en = 1'b0;
        ar_pulse(4);
        en = 1'b1;
        repeat (6) cyc();
        samp();
        chk("en0.no_req", reset_req, 0);

        // async reset mid-cycle drops sticky outputs immediately
        fb = 10'd0;
        ar_pulse(9);
        cyc(); samp();
        chk("arst.pre", reset_req, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst.req", reset_req, 0);
        chk("arst.irq", irq, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fb = 10'd5;

        // 6: PrescalerDiv=4, budget 2 -> expiry 8..12 cycles after AR
        ar4_valid = 1'b1; ar4_id = 4'd1;
        cyc();
        ar4_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (reset_req4) break;
            n = k;
            cyc();
        end
        if (!reset_req4) chk("t6.timeout_seen", 0, 1);
        else chk("t6.window", (n >= 8 && n <= 12) ? 1 : 0, 1);
        if (reset_req4) chk("t6.slot", timeout_slot4, 0);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
